// File: rtl/mtrx_fb_ctrl.sv
// mtrx_fb_ctrl: frame-buffer controller for the 32x32 LED matrix write port.
// Host pointer/data registers, a whole-buffer fill engine, host-priority
// write arbitration and a buffer swap sequencer.
// Optional feature macro: MTRX_SWAP_TIMEOUT_EN (abandon an unacknowledged
// swap after SWAP_TIMEOUT cycles and flag it in a sticky status bit).
module mtrx_fb_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'h0008
`ifdef MTRX_SWAP_TIMEOUT_EN
    , parameter int unsigned SWAP_TIMEOUT = 1048576
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sb_wr,
    input  logic        sb_rd,
    input  logic [15:0] sb_addr,
    input  logic [15:0] sb_wr_data,
    output logic [15:0] rd_data,
    output logic        rd_hit,
    output logic        mtrx_wr,
    output logic [10:0] mtrx_wr_addr,
    output logic [11:0] mtrx_wr_data,
    output logic        buffer_select,
    input  logic        buffer_current
);

    typedef enum logic [1:0] {IDLE, FILL, SWAP_WAIT} state_t;

    state_t      state_q, state_d;
    logic [10:0] ptr_q, ptr_d;
    logic [11:0] fill_color_q, fill_color_d;
    logic [11:0] fill_cur_q, fill_cur_d;
    logic [9:0]  idx_q, idx_d;
    logic        fill_pending_q, fill_pending_d;
    logic        swap_pending_q, swap_pending_d;
    logic        buffer_select_q, buffer_select_d;
    logic        fill_wr_q, fill_wr_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_hit_q, rd_hit_d;
    logic        mtrx_wr_q, mtrx_wr_d;
    logic [10:0] mtrx_wr_addr_q, mtrx_wr_addr_d;
    logic [11:0] mtrx_wr_data_q, mtrx_wr_data_d;
    logic        tmo_bit;

`ifdef MTRX_SWAP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(SWAP_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(SWAP_TIMEOUT - 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          swap_timeout_q, swap_timeout_d;
`endif

    logic [15:0] off;
    logic        hit, wr_ptr, wr_data, wr_ctrl, wr_color;
    logic        fill_issue, fill_busy, swap_busy;
    logic [15:0] status;
    logic        unused_wr_bits;

    // Register decode and status word assembly
    always_comb begin
        off      = sb_addr - BASE_ADDR;
        hit      = (off < 16'd5);
        wr_ptr   = sb_wr && (off == 16'd0);
        wr_data  = sb_wr && (off == 16'd1);
        wr_ctrl  = sb_wr && (off == 16'd2);
        wr_color = sb_wr && (off == 16'd3);
`ifdef MTRX_SWAP_TIMEOUT_EN
        tmo_bit  = swap_timeout_q;
`else
        tmo_bit  = 1'b0;
`endif
        // fill_busy stays up while the last fill write is still on the port
        fill_busy = fill_pending_q || (state_q == FILL) || fill_wr_q;
        swap_busy = swap_pending_q ||
                    ((state_q == SWAP_WAIT) && (buffer_current != buffer_select_q));
        status    = {10'd0, fill_pending_q, tmo_bit, buffer_select_q,
                     buffer_current, swap_busy, fill_busy};
        unused_wr_bits = ^sb_wr_data[15:12];
    end

    // Sequencer: request capture, fill engine stepping and swap handshake
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        fill_cur_d      = fill_cur_q;
        fill_pending_d  = fill_pending_q;
        swap_pending_d  = swap_pending_q;
        buffer_select_d = buffer_select_q;
        fill_issue      = 1'b0;
`ifdef MTRX_SWAP_TIMEOUT_EN
        tmo_cnt_d       = tmo_cnt_q;
        swap_timeout_d  = swap_timeout_q;
        // clear first so a timeout landing on the same cycle still sticks
        if (wr_ctrl && sb_wr_data[2]) swap_timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (fill_pending_q) begin
                    fill_pending_d = 1'b0;
                    idx_d          = 10'd0;
                    fill_cur_d     = fill_color_q;
                    state_d        = FILL;
                end else if (swap_pending_q) begin
                    swap_pending_d  = 1'b0;
                    buffer_select_d = ~buffer_select_q;
                    state_d         = SWAP_WAIT;
`ifdef MTRX_SWAP_TIMEOUT_EN
                    tmo_cnt_d       = '0;
`endif
                end
            end
            FILL: begin
                // a host DATA write owns the port this cycle; the fill waits
                if (!wr_data) begin
                    fill_issue = 1'b1;
                    idx_d      = idx_q + 10'd1;
                    if (idx_q == 10'd1023) state_d = IDLE;
                end
            end
            SWAP_WAIT: begin
                if (buffer_current == buffer_select_q) begin
                    state_d = IDLE;
`ifdef MTRX_SWAP_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    swap_timeout_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        // new requests win over the clear performed when IDLE consumes one
        if (wr_ctrl && sb_wr_data[0]) swap_pending_d = 1'b1;
        if (wr_ctrl && sb_wr_data[1]) fill_pending_d = 1'b1;
    end

    // Host registers, read port and registered write-port arbitration
    always_comb begin
        ptr_d          = ptr_q;
        fill_color_d   = fill_color_q;
        rd_data_d      = rd_data_q;
        rd_hit_d       = 1'b0;
        mtrx_wr_d      = 1'b0;
        mtrx_wr_addr_d = mtrx_wr_addr_q;
        mtrx_wr_data_d = mtrx_wr_data_q;
        fill_wr_d      = fill_issue;
        if (wr_ptr)   ptr_d        = sb_wr_data[10:0];
        if (wr_color) fill_color_d = sb_wr_data[11:0];
        if (wr_data) begin
            ptr_d          = ptr_q + 11'd1;
            mtrx_wr_d      = 1'b1;
            mtrx_wr_addr_d = ptr_q;
            mtrx_wr_data_d = sb_wr_data[11:0];
        end else if (fill_issue) begin
            mtrx_wr_d      = 1'b1;
            mtrx_wr_addr_d = {~buffer_select_q, idx_q};
            mtrx_wr_data_d = fill_cur_q;
        end
        if (sb_rd && hit) begin
            rd_hit_d = 1'b1;
            case (off[2:0])
                3'd0:    rd_data_d = {5'd0, ptr_q};
                3'd3:    rd_data_d = {4'd0, fill_color_q};
                3'd4:    rd_data_d = status;
                default: rd_data_d = 16'd0;
            endcase
        end
    end

    // Control and output state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            fill_color_q    <= '0;
            fill_pending_q  <= 1'b0;
            swap_pending_q  <= 1'b0;
            buffer_select_q <= 1'b0;
            fill_wr_q       <= 1'b0;
            rd_data_q       <= 16'hffff;
            rd_hit_q        <= 1'b0;
            mtrx_wr_q       <= 1'b0;
            mtrx_wr_addr_q  <= '0;
            mtrx_wr_data_q  <= '0;
`ifdef MTRX_SWAP_TIMEOUT_EN
            swap_timeout_q  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            fill_color_q    <= fill_color_d;
            fill_pending_q  <= fill_pending_d;
            swap_pending_q  <= swap_pending_d;
            buffer_select_q <= buffer_select_d;
            fill_wr_q       <= fill_wr_d;
            rd_data_q       <= rd_data_d;
            rd_hit_q        <= rd_hit_d;
            mtrx_wr_q       <= mtrx_wr_d;
            mtrx_wr_addr_q  <= mtrx_wr_addr_d;
            mtrx_wr_data_q  <= mtrx_wr_data_d;
`ifdef MTRX_SWAP_TIMEOUT_EN
            swap_timeout_q  <= swap_timeout_d;
`endif
        end
    end

    // Fill index, captured colour and timeout counter are loaded before use
    always_ff @(posedge clk) begin
        idx_q      <= idx_d;
        fill_cur_q <= fill_cur_d;
`ifdef MTRX_SWAP_TIMEOUT_EN
        tmo_cnt_q  <= tmo_cnt_d;
`endif
    end

    assign rd_data       = rd_data_q;
    assign rd_hit        = rd_hit_q;
    assign mtrx_wr       = mtrx_wr_q;
    assign mtrx_wr_addr  = mtrx_wr_addr_q;
    assign mtrx_wr_data  = mtrx_wr_data_q;
    assign buffer_select = buffer_select_q;

endmodule

// File: tb/tb_mtrx_fb_ctrl.sv
// Self-checking bench for mtrx_fb_ctrl: directed sequence with randomized
// data, pointers and colours checked against a simple behavioural model.
module tb_mtrx_fb_ctrl;
    localparam logic [15:0] BASE = 16'h0008;

    logic        clk = 1'b0;
    logic        rst, sb_wr, sb_rd, buffer_current;
    logic [15:0] sb_addr, sb_wr_data, rd_data;
    logic        rd_hit, mtrx_wr, buffer_select;
    logic [10:0] mtrx_wr_addr;
    logic [11:0] mtrx_wr_data;

    always #5 clk = ~clk;

    mtrx_fb_ctrl #(
        .BASE_ADDR(BASE)
`ifdef MTRX_SWAP_TIMEOUT_EN
        , .SWAP_TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .rst(rst), .sb_wr(sb_wr), .sb_rd(sb_rd), .sb_addr(sb_addr),
        .sb_wr_data(sb_wr_data), .rd_data(rd_data), .rd_hit(rd_hit),
        .mtrx_wr(mtrx_wr), .mtrx_wr_addr(mtrx_wr_addr), .mtrx_wr_data(mtrx_wr_data),
        .buffer_select(buffer_select), .buffer_current(buffer_current)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input int off, input logic [15:0] d);
        sb_addr    = BASE + 16'(off);
        sb_wr_data = d;
        sb_wr      = 1'b1;
        tick();
        sb_wr      = 1'b0;
    endtask

    task automatic bus_rd(input int off, output logic [15:0] d, output logic h);
        sb_addr = BASE + 16'(off);
        sb_rd   = 1'b1;
        tick();
        sb_rd   = 1'b0;
        d       = rd_data;
        h       = rd_hit;
    endtask

    // per-cycle capture buffers
    logic        wr_a [1600];
    logic [10:0] wa_a [1600];
    logic [11:0] wd_a [1600];
    logic [15:0] st_a [1600];
    logic        bs_a [1600];

    initial begin
        logic [15:0] d;
        logic        h;
        logic [10:0] model_ptr;
        logic [11:0] v, c, c2;
        logic [22:0] exp_q[$];
        logic [22:0] e;
        int nwr, last, k, tog, nhost, ok_fill, ok_host, prev_bs;

        rst = 1'b1; sb_wr = 1'b0; sb_rd = 1'b0; sb_addr = '0; sb_wr_data = '0;
        buffer_current = 1'b0;
        repeat (3) tick();
        chk("rst_rd_data", rd_data, 16'hffff);
        chk("rst_rd_hit", rd_hit, 0);
        chk("rst_mtrx_wr", mtrx_wr, 0);
        chk("rst_wr_addr", mtrx_wr_addr, 0);
        chk("rst_wr_data", mtrx_wr_data, 0);
        chk("rst_bufsel", buffer_select, 0);
        rst = 1'b0;
        tick();
        chk("idle_rd_data", rd_data, 16'hffff);

        // STATUS read after reset, then misses leave rd_data alone
        bus_rd(4, d, h);
        chk("status_hit", h, 1);
        chk("status_val", d, 16'h0000);
        tick();
        chk("hit_pulse_end", rd_hit, 0);
        bus_wr(3, 16'h0abc);
        bus_rd(5, d, h);
        chk("miss_hi_hit", h, 0);
        chk("miss_hi_data", d, 16'h0000);
        bus_rd(-1, d, h);
        chk("miss_lo_hit", h, 0);
        bus_rd(1, d, h);
        chk("data_reads_0", d, 16'h0000);
        bus_rd(3, d, h);
        chk("color_rb", d, 16'h0abc);

        // host pointer/data path with wrap
        model_ptr = 11'd2046;
        bus_wr(0, 16'd2046);
        for (int i = 0; i < 3; i++) begin
            v = 12'(16'h111 * (i + 1));
            bus_wr(1, {4'hf, v});
            chk("host_wr", mtrx_wr, 1);
            chk("host_addr", mtrx_wr_addr, model_ptr);
            chk("host_data", mtrx_wr_data, v);
            model_ptr = model_ptr + 11'd1;
        end
        tick();
        chk("host_wr_end", mtrx_wr, 0);
        bus_rd(0, d, h);
        chk("ptr_rb", d, 16'd1);
        for (int i = 0; i < 6; i++) begin
            model_ptr = 11'($urandom);
            bus_wr(0, {5'd0, model_ptr});
            for (int j = 0; j < 2; j++) begin
                v = 12'($urandom);
                bus_wr(1, {4'h0, v});
                chk("rnd_addr", mtrx_wr_addr, model_ptr);
                chk("rnd_data", mtrx_wr_data, v);
                model_ptr = model_ptr + 11'd1;
            end
            bus_rd(0, d, h);
            chk("rnd_ptr_rb", d, {5'd0, model_ptr});
        end

        // plain fill of the back buffer, busy tracking each cycle
        bus_wr(3, 16'h0f00);
        bus_wr(2, 16'h0002);
        for (int n = 0; n < 1200; n++) begin
            wr_a[n] = mtrx_wr; wa_a[n] = mtrx_wr_addr; wd_a[n] = mtrx_wr_data;
            sb_addr = BASE + 16'd4; sb_rd = 1'b1;
            tick();
            st_a[n] = rd_data;
        end
        sb_rd = 1'b0;
        nwr = 0; last = 0; ok_fill = 1;
        for (int n = 0; n < 1200; n++) if (wr_a[n]) begin
            if (wa_a[n] != 11'(1024 + nwr) || wd_a[n] != 12'hf00) ok_fill = 0;
            nwr++; last = n;
        end
        chk("fill1_count", nwr, 1024);
        chk("fill1_seq", ok_fill, 1);
        chk("fill1_busy_start", st_a[0][0], 1);
        chk("fill1_busy_last", st_a[last][0], 1);
        chk("fill1_busy_clear", st_a[last + 1][0], 0);

        // fill with interleaved host writes every 4th cycle
        c = 12'($urandom);
        c2 = ~c;
        model_ptr = 11'($urandom_range(0, 900));
        bus_wr(3, {4'h0, c});
        bus_wr(0, {5'd0, model_ptr});
        bus_wr(2, 16'h0002);
        exp_q.delete();
        for (int n = 0; n < 1300; n++) begin
            sb_wr = 1'b0;
            if (n % 4 == 0 && n < 160) begin
                v = 12'($urandom);
                sb_addr = BASE + 16'd1; sb_wr_data = {4'h0, v}; sb_wr = 1'b1;
                exp_q.push_back({model_ptr, v});
                model_ptr = model_ptr + 11'd1;
            end else if (n == 201) begin
                sb_addr = BASE + 16'd3; sb_wr_data = {4'h0, c2}; sb_wr = 1'b1;
            end
            tick();
            wr_a[n] = mtrx_wr; wa_a[n] = mtrx_wr_addr; wd_a[n] = mtrx_wr_data;
        end
        sb_wr = 1'b0;
        nwr = 0; nhost = 0; ok_fill = 1; ok_host = 1;
        for (int n = 0; n < 1300; n++) if (wr_a[n]) begin
            if (wa_a[n] < 11'd1024) begin
                if (exp_q.size() == 0) ok_host = 0;
                else begin
                    e = exp_q.pop_front();
                    if ({wa_a[n], wd_a[n]} != e) ok_host = 0;
                end
                nhost++;
            end else begin
                if (wa_a[n] != 11'(1024 + nwr) || wd_a[n] != c) ok_fill = 0;
                nwr++;
            end
        end
        chk("mix_host_count", nhost, 40);
        chk("mix_host_order", ok_host, 1);
        chk("mix_fill_count", nwr, 1024);
        chk("mix_fill_seq", ok_fill, 1);
        bus_rd(3, d, h);
        chk("mix_color_rb", d, {4'h0, c2});

        // reset in the middle of a fill aborts it
        bus_wr(2, 16'h0002);
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_wr", mtrx_wr, 0);
        chk("abort_addr", mtrx_wr_addr, 0);
        nwr = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (mtrx_wr) nwr++;
        end
        chk("abort_no_writes", nwr, 0);
        bus_rd(4, d, h);
        chk("abort_status", d, 16'h0000);

        // paint then show: display follows buffer_select 10 cycles late
        c = 12'($urandom);
        bus_wr(3, {4'h0, c});
        bus_wr(2, 16'h0003);
        tog = -100; prev_bs = 0;
        for (int n = 0; n < 1400; n++) begin
            wr_a[n] = mtrx_wr; wa_a[n] = mtrx_wr_addr; wd_a[n] = mtrx_wr_data;
            bs_a[n] = buffer_select;
            if (int'(buffer_select) != prev_bs) tog = n;
            prev_bs = int'(buffer_select);
            if (n == tog + 10) buffer_current = buffer_select;
            sb_addr = BASE + 16'd4; sb_rd = 1'b1;
            tick();
            st_a[n] = rd_data;
        end
        sb_rd = 1'b0;
        nwr = 0; last = 0; ok_fill = 1;
        for (int n = 0; n < 1400; n++) if (wr_a[n]) begin
            if (wa_a[n] != 11'(1024 + nwr) || wd_a[n] != c) ok_fill = 0;
            nwr++; last = n;
        end
        chk("ps_fill_count", nwr, 1024);
        chk("ps_fill_seq", ok_fill, 1);
        chk("ps_toggled", tog > 0, 1);
        chk("ps_swap_after_fill", tog > last, 1);
        if (tog < 1) tog = 1;
        chk("ps_swap_busy_wait", st_a[tog + 9][1], 1);
        chk("ps_swap_busy_match", st_a[tog + 10][1], 0);
        chk("ps_bufsel", buffer_select, 1);
        chk("ps_status_bits", st_a[1399][3:0], 4'b1100);

`ifdef MTRX_SWAP_TIMEOUT_EN
        // swap never acknowledged: timeout after 16 cycles
        bus_wr(2, 16'h0001);
        tog = 0;
        for (int n = 0; n < 40; n++) begin
            bs_a[n] = buffer_select;
            if (tog == 0 && !buffer_select) tog = n;
            sb_addr = BASE + 16'd4; sb_rd = 1'b1;
            tick();
            st_a[n] = rd_data;
        end
        sb_rd = 1'b0;
        chk("tmo_toggled", tog, 1);
        chk("tmo_before", st_a[tog + 15][4], 0);
        chk("tmo_busy_before", st_a[tog + 15][1], 1);
        chk("tmo_set", st_a[tog + 16][4], 1);
        chk("tmo_busy_after", st_a[tog + 16][1], 0);
        chk("tmo_bufsel_kept", buffer_select, 0);
        bus_wr(2, 16'h0004);
        bus_rd(4, d, h);
        chk("tmo_cleared", d[4], 0);
`else
        // swap never acknowledged: waits indefinitely, no timeout flag
        bus_wr(2, 16'h0005);
        repeat (40) tick();
        bus_rd(4, d, h);
        chk("noto_busy", d[1], 1);
        chk("noto_bit4", d[4], 0);
        chk("noto_bufsel", buffer_select, 0);
        buffer_current = 1'b0;
        tick();
        bus_rd(4, d, h);
        chk("noto_done", d[1], 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
